// File: rtl/vend_pkg.sv
// Shared types and money tables for the vending transaction controller.
// All money values are in half-units.
package vend_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_WELCOME,
        S_SELECT,
        S_PAY,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND
    } state_t;

    localparam int TW = 6;
    localparam logic [2:0] MAX_QTY = 3'd5;
    localparam logic [2:0] MAX_ITEM = 3'd5;

    function automatic logic [5:0] coin_half(input logic [1:0] t);
        case (t)
            2'd0:    coin_half = 6'd1;
            2'd1:    coin_half = 6'd2;
            2'd2:    coin_half = 6'd10;
            default: coin_half = 6'd20;
        endcase
    endfunction

    function automatic logic [5:0] price_half(input logic [2:0] id);
        case (id)
            3'd0:    price_half = 6'd2;
            3'd1:    price_half = 6'd3;
            3'd2:    price_half = 6'd4;
            3'd3:    price_half = 6'd5;
            3'd4:    price_half = 6'd6;
            3'd5:    price_half = 6'd7;
            default: price_half = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter with tick enable; zero flag when expired.
// Load wins over a coincident tick.
module vend_timer #(
    parameter int W = 6
) (
    input  logic         clk_N,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_N) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending front-panel transaction FSM: selection, coins, dispense,
// change and refund, feeding the seven-segment display driver.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int TIMEOUT_S = 30,
    parameter int DISP_CYC  = 8,
    parameter int CHANGE_S  = 3,
    parameter int MAX_HALF  = 39
) (
    input  logic       clk_N,
    input  logic       reset,
    input  logic       open,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       item_sel,
    input  logic [2:0] item_id,
    input  logic       qty_up,
    input  logic       coin_strobe,
    input  logic [1:0] coin_type,
    input  logic       confirm,
    input  logic       cancel,
    output logic       hold_ind,
    output logic       coin_in,
    output logic       op_start,
    output logic       cancel_flag,
    output logic [4:0] coin_val,
    output logic       coin_float,
    output logic [4:0] charge_val,
    output logic       charge_float,
    output logic [4:0] num1,
    output logic [4:0] num2,
    output logic       dispense,
    output logic       coin_reject
);

    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_S);
    localparam logic [TW-1:0] T_DISP    = TW'(DISP_CYC - 1);
    localparam logic [TW-1:0] T_CHANGE  = TW'(CHANGE_S);
    localparam logic [5:0]    MAX_H     = 6'(MAX_HALF);

    state_t state;
    logic [5:0] amount;
    logic [5:0] change;
    logic [2:0] item;
    logic [2:0] qty;

    logic [5:0] sum;
    logic [5:0] total;
    logic active, live, expired;
    logic cancel_hit, buy, coin_ok;
    logic sel_ok, qty_ok, touch, to_refund;
    logic tmr_load, tmr_tick, tmr_zero;
    logic [TW-1:0] tmr_val;

    assign sum   = amount + coin_half(coin_type);
    assign total = price_half(item) * {3'b000, qty};

    assign active     = open && (state == S_SELECT || state == S_PAY);
    assign cancel_hit = active && cancel;
    assign live       = active && !cancel && !tmr_zero;
    assign expired    = active && !cancel && tmr_zero;
    assign to_refund  = cancel_hit || (expired && amount != '0);

    // cancel beats confirm, confirm beats a coin in the same cycle
    assign buy     = live && state == S_PAY && confirm && amount >= total;
    assign coin_ok = live && coin_strobe && !buy && sum <= MAX_H;
    assign sel_ok  = live && state == S_SELECT && item_sel
                     && item_id <= MAX_ITEM;
    assign qty_ok  = live && state == S_SELECT && qty_up;
    assign touch   = sel_ok || qty_ok || coin_ok || buy;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = T_TIMEOUT;
        if (open) begin
            case (state)
                S_WELCOME: tmr_load = start;
                S_SELECT, S_PAY: begin
                    if (to_refund) begin
                        tmr_load = 1'b1;
                        tmr_val  = T_CHANGE;
                    end else if (buy) begin
                        tmr_load = 1'b1;
                        tmr_val  = T_DISP;
                    end else if (touch) begin
                        tmr_load = 1'b1;
                    end
                end
                S_DISPENSE: begin
                    tmr_load = tmr_zero;
                    tmr_val  = T_CHANGE;
                end
                S_CHANGE: tmr_load = tmr_zero;
                default: ;
            endcase
        end
    end

    // the dispense window counts clock cycles, everything else seconds
    assign tmr_tick = (state == S_DISPENSE) || tick_1hz;

    vend_timer #(.W(TW)) u_timer (
        .clk_N    (clk_N),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_N) begin
        if (!reset) begin
            state       <= S_OFF;
            amount      <= '0;
            change      <= '0;
            item        <= '0;
            qty         <= '0;
            hold_ind    <= 1'b0;
            coin_in     <= 1'b0;
            op_start    <= 1'b0;
            cancel_flag <= 1'b0;
            dispense    <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            coin_in     <= coin_ok;
            op_start    <= buy;
            coin_reject <= coin_strobe && !coin_ok;
            cancel_flag <= 1'b0;
            if (!open) begin
                state    <= S_OFF;
                amount   <= '0;
                change   <= '0;
                item     <= '0;
                qty      <= '0;
                hold_ind <= 1'b0;
                dispense <= 1'b0;
            end else begin
                case (state)
                    S_OFF: state <= S_WELCOME;
                    S_WELCOME: begin
                        if (start) begin
                            state    <= S_SELECT;
                            hold_ind <= 1'b1;
                            item     <= '0;
                            qty      <= 3'd1;
                            amount   <= '0;
                        end
                    end
                    S_SELECT, S_PAY: begin
                        if (to_refund) begin
                            state       <= S_REFUND;
                            change      <= amount;
                            amount      <= '0;
                            cancel_flag <= 1'b1;
                        end else if (expired) begin
                            state    <= S_WELCOME;
                            hold_ind <= 1'b0;
                        end else begin
                            if (buy) begin
                                state    <= S_DISPENSE;
                                dispense <= 1'b1;
                                change   <= amount - total;
                            end
                            if (coin_ok) begin
                                state  <= S_PAY;
                                amount <= sum;
                            end
                            if (sel_ok) begin
                                item <= item_id;
                                qty  <= 3'd1;
                            end else if (qty_ok && qty < MAX_QTY) begin
                                qty <= qty + 3'd1;
                            end
                        end
                    end
                    S_DISPENSE: begin
                        if (tmr_zero) begin
                            state    <= S_CHANGE;
                            dispense <= 1'b0;
                            amount   <= '0;
                        end
                    end
                    S_CHANGE: begin
                        if (tmr_zero) begin
                            state  <= S_SELECT;
                            change <= '0;
                            item   <= '0;
                            qty    <= 3'd1;
                        end
                    end
                    S_REFUND: begin
                        if (tmr_zero) begin
                            state    <= S_WELCOME;
                            change   <= '0;
                            hold_ind <= 1'b0;
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end

    assign coin_val     = amount[5:1];
    assign coin_float   = amount[0];
    assign charge_val   = change[5:1];
    assign charge_float = change[0];
    assign num1         = {2'b00, item};
    assign num2         = {2'b00, qty};

endmodule
